fifo_rd_unpack: RTL and testbench

//   Read-side consumer for the DFF FIFO read port (data_out/empty/pop, first-word-fall-through).

---
 rtl/fifo_rd_unpack_if.sv | 24 ++
 rtl/fifo_rd_unpack.sv | 116 +++++++++++
 tb/tb_fifo_rd_unpack.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_unpack_if.sv
// Handshake bundle for fifo_rd_unpack: wide FIFO read port (FWFT) plus the narrow
// valid/ready output stream. master = unpacker side, slave = FIFO/downstream side.
interface fifo_rd_unpack_if #(
    parameter int IN_WIDTH  = 256,
    parameter int OUT_WIDTH = 64
);
    logic [IN_WIDTH-1:0]  fifo_data;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic                 m_valid;
    logic                 m_ready;
    logic [OUT_WIDTH-1:0] m_data;
    logic                 m_last;

    modport master (
        input  fifo_data, fifo_empty, m_ready,
        output fifo_pop, m_valid, m_data, m_last
    );

    modport slave (
        output fifo_data, fifo_empty, m_ready,
        input  fifo_pop, m_valid, m_data, m_last
    );
endinterface

// File: rtl/fifo_rd_unpack.sv
// Pops IN_WIDTH words from a first-word-fall-through FIFO and replays each as RATIO
// OUT_WIDTH beats (LSB first). Optional stall counter under FIFO_RD_UNPACK_PERF_EN.
module fifo_rd_unpack #(
    parameter int IN_WIDTH   = 256,
    parameter int OUT_WIDTH  = 64,
    parameter int RATIO      = IN_WIDTH / OUT_WIDTH,
    parameter int log2_RATIO = $clog2(RATIO)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    fifo_rd_unpack_if.master       bus,
    output logic                   busy
`ifdef FIFO_RD_UNPACK_PERF_EN
    ,
    output logic [31:0]            stall_cnt
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    localparam logic [log2_RATIO-1:0] LAST_BEAT = log2_RATIO'(RATIO - 1);

    state_e                state_q, state_d;
    logic [IN_WIDTH-1:0]   hold_q, hold_d;
    logic [log2_RATIO-1:0] beat_cnt_q, beat_cnt_d;

    logic                  valid;
    logic                  at_last;
    logic                  accept;
    logic                  last_acc;
    logic                  pop;
    logic [OUT_WIDTH-1:0]  beat_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            hold_q     <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        valid    = (state_q == FULL);
        at_last  = (beat_cnt_q == LAST_BEAT);
        accept   = valid & bus.m_ready;
        last_acc = accept & at_last;
        // Refill on the final accepted beat so back-to-back words stream without a bubble.
        pop      = rst_n & ~clr & ~bus.fifo_empty & ((state_q == EMPTY) | last_acc);

        state_d    = state_q;
        hold_d     = hold_q;
        beat_cnt_d = beat_cnt_q;

        if (clr) begin
            state_d    = EMPTY;
            hold_d     = '0;
            beat_cnt_d = '0;
        end else if (pop) begin
            state_d    = FULL;
            hold_d     = bus.fifo_data;
            beat_cnt_d = '0;
        end else if (last_acc) begin
            state_d    = EMPTY;
            beat_cnt_d = '0;
        end else if (accept) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
        end
    end

    always_comb begin
        beat_data = '0;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (beat_cnt_q == log2_RATIO'(i)) begin
                beat_data = hold_q[i*OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

    assign bus.fifo_pop = pop;
    assign bus.m_valid  = valid;
    assign bus.m_data   = beat_data;
    assign bus.m_last   = valid & at_last;
    assign busy         = valid;

`ifdef FIFO_RD_UNPACK_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (clr) begin
            stall_cnt_d = '0;
        end else if (valid && !bus.m_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_unpack.sv
// Directed bench for fifo_rd_unpack: queue-backed FWFT FIFO source, checks at negedge.
module tb_fifo_rd_unpack;
    localparam int IN_WIDTH  = 256;
    localparam int OUT_WIDTH = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clr   = 1'b0;
    logic busy;
`ifdef FIFO_RD_UNPACK_PERF_EN
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int pops   = 0;

    logic [IN_WIDTH-1:0] fq[$];
    logic                pop_seen;

    fifo_rd_unpack_if #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) bus ();

    fifo_rd_unpack #(
        .IN_WIDTH (IN_WIDTH),
        .OUT_WIDTH(OUT_WIDTH),
        .RATIO    (4),
        .log2_RATIO(2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .bus      (bus),
        .busy     (busy)
`ifdef FIFO_RD_UNPACK_PERF_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Word whose beats are nibble d, d+1, d+2, d+3 repeated (LSB beat = d).
    function automatic logic [IN_WIDTH-1:0] mk_word(input logic [3:0] d);
        logic [3:0] d1, d2, d3;
        d1 = d + 4'd1;
        d2 = d + 4'd2;
        d3 = d + 4'd3;
        return {{16{d3}}, {16{d2}}, {16{d1}}, {16{d}}};
    endfunction

    function automatic logic [OUT_WIDTH-1:0] beat(input logic [3:0] d);
        return {16{d}};
    endfunction

    task automatic refresh();
        bus.fifo_empty = (fq.size() == 0);
        bus.fifo_data  = (fq.size() != 0) ? fq[0] : '0;
    endtask

    task automatic push(input logic [IN_WIDTH-1:0] w);
        fq.push_back(w);
        refresh();
    endtask

    // Called at a negedge: capture pop, cross one posedge, retire the popped word, return at next negedge.
    task automatic adv();
        #1 pop_seen = bus.fifo_pop;
        @(posedge clk);
        #1;
        if (pop_seen && fq.size() != 0) begin
            void'(fq.pop_front());
            pops++;
        end
        refresh();
        @(negedge clk);
    endtask

    task automatic drain();
        bus.m_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!bus.m_valid && fq.size() == 0) break;
            adv();
        end
        checks++;
        if (bus.m_valid !== 1'b0 || fq.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: m_valid=%b fifo_words=%0d required 0/0", bus.m_valid, fq.size());
        end
    endtask

    task automatic test_reset();
        bus.m_ready = 1'b0;
        push(mk_word(4'h1));
        @(negedge clk);
        #1;
        checks++;
        if (bus.fifo_pop !== 1'b0) begin errors++; $display("FAIL rst_pop: got %b need 0", bus.fifo_pop); end
        checks++;
        if (bus.m_valid !== 1'b0 || busy !== 1'b0 || bus.m_last !== 1'b0) begin
            errors++; $display("FAIL rst_valid: valid=%b busy=%b last=%b need 0", bus.m_valid, busy, bus.m_last);
        end
        checks++;
        if (bus.m_data !== '0) begin errors++; $display("FAIL rst_data: got %h need 0", bus.m_data); end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.fifo_pop !== 1'b1) begin errors++; $display("FAIL rel_pop: got %b need 1", bus.fifo_pop); end
        adv();
        checks++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== beat(4'h1)) begin
            errors++; $display("FAIL rel_valid: valid=%b data=%h need 1/%h", bus.m_valid, bus.m_data, beat(4'h1));
        end
        drain();
    endtask

    task automatic test_single();
        bus.m_ready = 1'b1;
        push(mk_word(4'h1));
        #1;
        checks++;
        if (bus.fifo_pop !== 1'b1 || bus.m_valid !== 1'b0) begin
            errors++; $display("FAIL single_pop: pop=%b valid=%b need 1/0", bus.fifo_pop, bus.m_valid);
        end
        adv();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.m_valid !== 1'b1 || bus.m_data !== beat(4'(i + 1)) || bus.m_last !== (i == 3)
                || bus.fifo_pop !== 1'b0) begin
                errors++;
                $display("FAIL single_beat%0d: valid=%b data=%h last=%b pop=%b need 1/%h/%b/0",
                         i, bus.m_valid, bus.m_data, bus.m_last, bus.fifo_pop, beat(4'(i + 1)), (i == 3));
            end
            adv();
        end
        #1;
        checks++;
        if (bus.m_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL single_end: valid=%b busy=%b need 0", bus.m_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_pop;
        bus.m_ready = 1'b1;
        push(mk_word(4'h1));
        push(mk_word(4'h5));
        push(mk_word(4'h9));
        pops = 0;
        #1;
        checks++;
        if (bus.fifo_pop !== 1'b1) begin errors++; $display("FAIL b2b_first_pop: got %b need 1", bus.fifo_pop); end
        adv();
        for (int k = 0; k < 12; k++) begin
            exp_pop = (k == 3 || k == 7);
            checks++;
            if (bus.m_valid !== 1'b1 || bus.m_data !== beat(4'(k + 1)) || bus.m_last !== (k % 4 == 3)
                || bus.fifo_pop !== exp_pop) begin
                errors++;
                $display("FAIL b2b_beat%0d: valid=%b data=%h last=%b pop=%b need 1/%h/%b/%b",
                         k, bus.m_valid, bus.m_data, bus.m_last, bus.fifo_pop, beat(4'(k + 1)), (k % 4 == 3), exp_pop);
            end
            adv();
        end
        #1;
        checks++;
        if (bus.m_valid !== 1'b0 || pops != 3) begin
            errors++; $display("FAIL b2b_end: valid=%b pops=%0d need 0/3", bus.m_valid, pops);
        end
    endtask

    task automatic test_backpressure();
        bus.m_ready = 1'b1;
        push(mk_word(4'h5));
        push(mk_word(4'h9));
        #1;
        adv();
        adv();
        adv();
        bus.m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (bus.m_valid !== 1'b1 || bus.m_data !== beat(4'h7) || bus.m_last !== 1'b0 || bus.fifo_pop !== 1'b0) begin
                errors++;
                $display("FAIL stall%0d: valid=%b data=%h last=%b pop=%b need 1/%h/0/0",
                         i, bus.m_valid, bus.m_data, bus.m_last, bus.fifo_pop, beat(4'h7));
            end
            adv();
        end
`ifdef FIFO_RD_UNPACK_PERF_EN
        checks++;
        if (stall_cnt !== 32'd5) begin errors++; $display("FAIL stall_cnt: got %0d need 5", stall_cnt); end
`endif
        bus.m_ready = 1'b1;
        #1;
        checks++;
        if (bus.m_data !== beat(4'h7)) begin errors++; $display("FAIL resume_beat2: got %h need %h", bus.m_data, beat(4'h7)); end
        adv();
        checks++;
        if (bus.m_data !== beat(4'h8) || bus.m_last !== 1'b1 || bus.fifo_pop !== 1'b1) begin
            errors++; $display("FAIL resume_beat3: data=%h last=%b pop=%b need %h/1/1",
                               bus.m_data, bus.m_last, bus.fifo_pop, beat(4'h8));
        end
        drain();
    endtask

    task automatic test_clear();
        bus.m_ready = 1'b1;
        push(mk_word(4'h1));
        push(mk_word(4'h5));
        #1;
        adv();
        adv();
        clr = 1'b1;
        #1;
        checks++;
        if (bus.fifo_pop !== 1'b0 || bus.m_data !== beat(4'h2)) begin
            errors++; $display("FAIL clr_cycle: pop=%b data=%h need 0/%h", bus.fifo_pop, bus.m_data, beat(4'h2));
        end
        adv();
        clr = 1'b0;
        #1;
        checks++;
        if (bus.m_valid !== 1'b0 || bus.fifo_pop !== 1'b1) begin
            errors++; $display("FAIL clr_after: valid=%b pop=%b need 0/1", bus.m_valid, bus.fifo_pop);
        end
        adv();
        checks++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== beat(4'h5) || bus.m_last !== 1'b0) begin
            errors++; $display("FAIL clr_next_word: valid=%b data=%h last=%b need 1/%h/0",
                               bus.m_valid, bus.m_data, bus.m_last, beat(4'h5));
        end
        drain();
    endtask

    task automatic test_reset_mid();
        bus.m_ready = 1'b1;
        push(mk_word(4'h1));
        push(mk_word(4'h5));
        #1;
        adv();
        adv();
        adv();
        checks++;
        if (bus.m_data !== beat(4'h3)) begin errors++; $display("FAIL rmid_pre: got %h need %h", bus.m_data, beat(4'h3)); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.m_valid !== 1'b0 || bus.m_last !== 1'b0 || bus.m_data !== '0 || bus.fifo_pop !== 1'b0) begin
            errors++; $display("FAIL rmid_async: valid=%b last=%b data=%h pop=%b need 0",
                               bus.m_valid, bus.m_last, bus.m_data, bus.fifo_pop);
        end
        adv();
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.fifo_pop !== 1'b1) begin errors++; $display("FAIL rmid_rel_pop: got %b need 1", bus.fifo_pop); end
        adv();
        checks++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== beat(4'h5)) begin
            errors++; $display("FAIL rmid_next_word: valid=%b data=%h need 1/%h", bus.m_valid, bus.m_data, beat(4'h5));
        end
        drain();
    endtask

    initial begin
        bus.m_ready = 1'b0;
        refresh();
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_clear();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
